// File: rtl/fifo_defs.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_defs (package)
//  Purpose  : Shared constants and sizing helpers for the FIFO read path.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_defs;

    localparam int DEFAULT_WIDTH = 8;
    localparam int LAT_MIN       = 1;
    localparam int LAT_MAX       = 2;

    // The skid store holds one entry per cycle of read latency plus one.
    // That covers the full round trip from a pop back to freshly read data.
    function automatic int calc_buf_depth(input int lat);
        return lat + 1;
    endfunction

    // Never return a zero-width pointer, even for a degenerate depth.
    function automatic int calc_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_reader_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_reader_buf
//  Purpose  : Small circular skid store that sits between the RAM return
//             path and the downstream stream. The head entry drives out_data.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_reader_buf
    import fifo_defs::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = 2,
    localparam int PTR_W = calc_ptr_width(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [OCC_W-1:0] occ_o
);

    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Pointer advance with wrap; push and pop together leave occupancy alone.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
        if (pop_i) begin
            head_d = (head_q == c_last_ptr) ? '0 : head_q + 1'b1;
        end
        if (push_i) begin
            tail_d = (tail_q == c_last_ptr) ? '0 : tail_q + 1'b1;
        end
    end

    // Storage and pointer registers. Storage is cleared so out_data is 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
            end
        end
    end

    // The head slot only changes on a pop. A push never lands on the head slot
    // while the store holds data. So this output is stable under backpressure.
    assign head_data_o = mem_q[head_q];
    assign occ_o       = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_reader
//  Purpose  : Read-side consumer for a FIFO controller + RAM pair. Issues reads
//             against fifo_empty, tracks reads in flight through the RAM
//             latency, and streams returned words out via valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_reader
    import fifo_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_read_req,
    input  logic [WIDTH-1:0] ram_read_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int BUF_DEPTH = calc_buf_depth(LAT);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int LVL_W     = OCC_W + 1;

    generate
        if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_check
            $error("fifo_reader: LAT must be between 1 and 2");
        end
    endgenerate

    logic [LAT-1:0]   infl_q, infl_d;
    logic [OCC_W-1:0] occ;
    logic [LVL_W-1:0] inflight;
    logic [LVL_W-1:0] level;
    logic             pop;
    logic             push;

    // One valid bit per pipeline stage of the RAM read; the last stage marks returning data.
    generate
        if (LAT == 1) begin : g_infl_single
            assign infl_d = fifo_read_req;
        end else begin : g_infl_shift
            assign infl_d = {infl_q[LAT-2:0], fifo_read_req};
        end
    endgenerate

    // In-flight tracker. Reset drops reads still in the RAM pipe, so their data is never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_q <= '0;
        end else begin
            infl_q <= infl_d;
        end
    end

    // Count of reads issued but not yet returned.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + LVL_W'(infl_q[i]);
        end
    end

    assign push = infl_q[LAT-1];
    assign pop  = out_valid && out_ready;

    // Reserve a store slot for every read in flight. The slot freed by a pop
    // this cycle counts as available, which keeps the stream gap-free.
    assign level         = LVL_W'(occ) + inflight - LVL_W'(pop);
    assign fifo_read_req = !rst && !fifo_empty && (level < LVL_W'(BUF_DEPTH));

    fifo_reader_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (ram_read_data),
        .pop_i       (pop),
        .head_data_o (out_data),
        .occ_o       (occ)
    );

    assign out_valid = (occ != '0);

endmodule
`default_nettype wire

// File: doc/fifo_reader.md
# fifo_reader

Read-side consumer for the FIFO controller and its dual-port RAM. It issues read requests against the controller's `fifo_empty` flag and captures the RAM read data after a fixed latency. It buffers that data in a small skid store and presents it downstream as a `valid`/`ready` stream with full throughput and no data loss under backpressure. It sits between the FIFO/RAM pair and any streaming sink.

## Interface
Parameters:
- `WIDTH`, default 8: data width; must match the FIFO data width.
- `LAT`, default 1: RAM read latency in cycles; legal values are 1 and 2.
- `BUF_DEPTH`, derived as `LAT+1`: number of entries in the skid store; not overridable.

Ports:
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `fifo_empty` input 1: registered empty flag from the FIFO controller; authoritative.
- `fifo_read_req` output 1: read request to the FIFO controller; combinational.
- `ram_read_data` input `WIDTH`: RAM read port data.
- `out_valid` output 1: downstream data valid.
- `out_ready` input 1: downstream accept.
- `out_data` output `WIDTH`: downstream data; registered.

## Operation
**Read accept**
- A read is accepted at a rising edge when `fifo_read_req` is 1.
- `fifo_read_req` = `!rst && !fifo_empty && (occ + inflight - pop) < BUF_DEPTH`.
  - `occ` is the skid store occupancy, range 0 to `BUF_DEPTH`.
  - `inflight` is the count of accepted reads whose data has not yet returned, range 0 to `LAT`.
  - `pop` = `out_valid && out_ready`.

**In-flight tracking**
- Tracked as a `LAT`-deep shift register of valid bits.
- Stage 0 is loaded with the read-accept value each cycle; the data-return signal is the last stage.

**Data return and capture**
- `ram_read_data` is sampled on the `LAT`-th rising edge after the accepting edge.
- At that edge it is written to the tail of the skid store.

**Skid store**
- Circular buffer with head and tail pointers, each of width `$clog2(BUF_DEPTH)`.
- Pointers wrap from `BUF_DEPTH-1` to 0.
- `out_data` is the head entry; `out_valid` = (`occ != 0`).
- **Simultaneous push and pop:** `occ` is unchanged; the head advances and the tail is written in the same cycle.
- **Push into an empty store:** the word appears on `out_data` the next cycle.

**Overflow safety**
- The request rule guarantees `occ + inflight <= BUF_DEPTH` at all times.
- A push into a full store is impossible; the testbench asserts this.

**Backpressure**
- While `out_valid && !out_ready`, `out_data` holds stable.
- Once the store plus in-flight reads reach `BUF_DEPTH`, `fifo_read_req` deasserts.
- It reasserts in the same cycle that a pop occurs.

**Reset, including mid-operation**
- Clears `occ`, both pointers, the in-flight shift register and `out_data`.
- Data returning after reset from reads accepted before reset is discarded.
- The FIFO controller is reset together with this block, so no words are orphaned.

**Ordering**
- Words leave in exactly the order they were read; none are duplicated and none are dropped.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `fifo_read_req`=0 while `rst`=1.
- First-word latency: reads are accepted at edge 0 and `out_valid` rises in the cycle following edge `LAT`.
  - With `fifo_empty` low and the store empty, `fifo_read_req` is high in the same cycle (combinational).
- Steady state with `out_ready`=1 and `fifo_empty`=0: one word per cycle with no bubbles.
- From `out_ready` rising under backpressure to the next read request: 0 cycles (same cycle).
- From the next read request to new data arriving in the store: `LAT` cycles.
  - `BUF_DEPTH` = `LAT+1` covers this latency, so no bubble occurs.
- `fifo_empty` is used as sampled. The controller raises it on the edge of the last read, so it is never stale by more than that one cycle.

## Structure
- Shared package/header `fifo_defs`:
  - default `WIDTH`;
  - `LAT_MIN`=1 and `LAT_MAX`=2;
  - helper function for `BUF_DEPTH` and pointer width.
- Sub-module `fifo_reader_buf`: the `BUF_DEPTH`-entry circular skid store.
  - Inputs: push, push data, pop.
  - Outputs: head data, `occ`.
- Top level `fifo_reader` contains the request rule and the in-flight shift register.
- Elaboration check: fail if `LAT` is outside 1 to 2.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `fifo_empty`=0 and `out_ready`=1 → `fifo_read_req`=0, `out_valid`=0, `out_data`=0 throughout.
- **Streaming, `LAT`=1:** FIFO holds 0x11, 0x22, 0x33, 0x44 and `out_ready`=1 → `fifo_read_req` is high for 4 cycles; `out_valid` is high for the 4 consecutive cycles after a 1-cycle latency, with data in order; `fifo_read_req`=0 after `fifo_empty` rises.
- **Backpressure:**
  - Setup: FIFO holds 10 words 0x00 to 0x09 and `out_ready`=0.
  - Expected reads: exactly 2 (`LAT`=1) or 3 (`LAT`=2), then `fifo_read_req`=0 and `out_data` holds 0x00.
  - Release `out_ready` → all 10 words delivered in order, with none duplicated or missing.
- **Empty gating:** `fifo_empty`=1 for 20 cycles → `fifo_read_req` is never 1; pulse `fifo_empty` low for 1 cycle → exactly one read and one output word.
- **Reset mid-flight, `LAT`=2:**
  - Stimulus: assert `rst` the cycle after 2 reads are accepted.
  - Expected: `out_valid` stays 0 and the returning 2 words are discarded.
  - After reset, a fresh word 0xA5 is delivered correctly.
- **Random sink, `LAT`=2:** 256 incrementing words with random `out_ready` at 50% → scoreboard exact match; `occ + inflight` never exceeds 3; throughput is 1 word per cycle during windows where `out_ready`=1.
